// File: rtl/serial_sub.sv
// Digit-serial subtractor: d = a - b - bin, one DIGIT-bit slice per cycle, LSB first.
// Operands arrive and results leave through valid/ready handshakes.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bor,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = DIGIT + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bor_q, bor_d, zero_q, zero_d, ovf_q, ovf_d;
    logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic [DIGIT:0]   slice;
    logic             last;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bor_d    = bor_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        slice    = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - SW'(borrow_q);
        last     = (cnt_q == CW'(N - 1));
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    acc_d    = '0;
                    amsb_d   = a[WIDTH-1];
                    bmsb_d   = b[WIDTH-1];
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                borrow_d = slice[DIGIT];
                cnt_d    = cnt_q + CW'(1);
                for (int unsigned k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) acc_d[k*DIGIT +: DIGIT] = slice[DIGIT-1:0];
                end
                // Visible results update only here, from the fully assembled difference.
                if (last) begin
                    state_d = DONE;
                    d_d     = acc_d;
                    bor_d   = slice[DIGIT];
                    zero_d  = (acc_d == '0);
                    ovf_d   = (amsb_q ^ bmsb_q) & (acc_d[WIDTH-1] ^ amsb_q);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bor_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bor_q    <= bor_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bor       = bor_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomised checks of serial_sub across several WIDTH/DIGIT configurations.
module tb_serial_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, bin;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    logic [3:0]  in_ready8, out_valid8, bor8, zero8, ovf8;
    logic [7:0]  d8 [4];
    logic        in_ready16, out_valid16, bor16, zero16, ovf16;
    logic [15:0] d16;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // Instance 0 (DIGIT=1) is the main device for the directed tests.
    for (genvar i = 0; i < 4; i++) begin : g_w8
        serial_sub #(.WIDTH(8), .DIGIT(1 << i)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready8[i]),
            .a(a8), .b(b8), .bin(bin),
            .out_valid(out_valid8[i]), .out_ready(out_ready),
            .d(d8[i]), .bor(bor8[i]), .zero(zero8[i]), .ovf(ovf8[i])
        );
    end

    serial_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready16),
        .a(a16), .b(b16), .bin(bin),
        .out_valid(out_valid16), .out_ready(out_ready),
        .d(d16), .bor(bor16), .zero(zero16), .ovf(ovf16)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one operation on the 8-bit devices and wait for DUT0 to finish.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic bi, output int lat);
        @(negedge clk);
        a8 = av; b8 = bv; bin = bi; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid8[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release8();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready8[0] !== 1'b1 || out_valid8[0] !== 1'b0 || d8[0] !== 8'h00 ||
            bor8[0] !== 1'b0 || zero8[0] !== 1'b0 || ovf8[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b d=%h bor=%b z=%b ovf=%b, need 1 0 00 0 0 0",
                     in_ready8[0], out_valid8[0], d8[0], bor8[0], zero8[0], ovf8[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready8[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b need 1", in_ready8[0]);
        end
    endtask

    task automatic test_arith(input string name, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                              input logic [7:0] ed, input logic eb, input logic ez, input logic eo);
        int lat;
        issue8(av, bv, bi, lat);
        vectors++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL %s_latency: got %0d need 8", name, lat);
        end
        vectors++;
        if (d8[0] !== ed || bor8[0] !== eb || zero8[0] !== ez || ovf8[0] !== eo) begin
            errors++;
            $display("FAIL %s: d=%h bor=%b z=%b ovf=%b, need d=%h bor=%b z=%b ovf=%b",
                     name, d8[0], bor8[0], zero8[0], ovf8[0], ed, eb, ez, eo);
        end
        release8();
        vectors++;
        if (in_ready8[0] !== 1'b1 || out_valid8[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s_handshake: rdy=%b vld=%b need 1 0", name, in_ready8[0], out_valid8[0]);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [7:0] held;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (!out_valid8[0] && cyc < 40) begin
            a8 = a8 + 8'h37; b8 = b8 ^ 8'h5A; bin = ~bin;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (d8[0] !== 8'h0F || bor8[0] !== 1'b0 || cyc !== 8) begin
            errors++;
            $display("FAIL busy_ignore: d=%h bor=%b lat=%0d need d=0f bor=0 lat=8", d8[0], bor8[0], cyc);
        end
        held = d8[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (d8[0] !== held || out_valid8[0] !== 1'b1 || in_ready8[0] !== 1'b0 || bor8[0] !== 1'b0) begin
                errors++;
                $display("FAIL done_hold: cycle %0d d=%h vld=%b rdy=%b need d=%h vld=1 rdy=0",
                         i, d8[0], out_valid8[0], in_ready8[0], held);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready8[0] !== 1'b1 || out_valid8[0] !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_handshake: rdy=%b vld=%b need 1 0", in_ready8[0], out_valid8[0]);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid8[0] !== 1'b0 || d8[0] !== 8'h00 || in_ready8[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_run: vld=%b d=%h rdy=%b need 0 00 1", out_valid8[0], d8[0], in_ready8[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue8(8'hA5, 8'h5A, 1'b0, lat);
        vectors++;
        if (d8[0] !== 8'h4B || bor8[0] !== 1'b0 || lat !== 8) begin
            errors++;
            $display("FAIL post_reset_op: d=%h bor=%b lat=%0d need d=4b bor=0 lat=8", d8[0], bor8[0], lat);
        end
        release8();
    endtask

    task automatic test_sweep();
        int lat [5];
        int need [5];
        logic [8:0]  r8;
        logic [16:0] r16;
        int cyc;
        need = '{8, 4, 2, 1, 4};
        do_reset();
        for (int it = 0; it < 1000; it++) begin
            @(negedge clk);
            a16 = 16'($urandom); b16 = 16'($urandom); bin = 1'($urandom);
            if (it == 0) begin a16 = 16'h0000; b16 = 16'h0000; bin = 1'b1; end
            if (it == 1) begin a16 = 16'hFFFF; b16 = 16'hFFFF; bin = 1'b0; end
            a8 = a16[7:0]; b8 = b16[7:0];
            in_valid = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            for (int k = 0; k < 5; k++) lat[k] = -1;
            cyc = 0;
            while ((lat[0] < 0 || lat[4] < 0) && cyc < 30) begin
                @(negedge clk);
                cyc++;
                for (int k = 0; k < 4; k++) if (out_valid8[k] && lat[k] < 0) lat[k] = cyc;
                if (out_valid16 && lat[4] < 0) lat[4] = cyc;
            end
            r8  = {1'b0, a8} - {1'b0, b8} - 9'(bin);
            r16 = {1'b0, a16} - {1'b0, b16} - 17'(bin);
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (lat[k] !== need[k] || d8[k] !== r8[7:0] || bor8[k] !== r8[8] ||
                    zero8[k] !== (r8[7:0] == 8'h00) ||
                    ovf8[k] !== ((a8[7] ^ b8[7]) & (r8[7] ^ a8[7]))) begin
                    errors++;
                    $display("FAIL sweep_w8_d%0d: a=%h b=%h bin=%b got d=%h bor=%b z=%b ovf=%b lat=%0d need d=%h bor=%b lat=%0d",
                             1 << k, a8, b8, bin, d8[k], bor8[k], zero8[k], ovf8[k], lat[k], r8[7:0], r8[8], need[k]);
                end
            end
            vectors++;
            if (lat[4] !== need[4] || d16 !== r16[15:0] || bor16 !== r16[16] ||
                zero16 !== (r16[15:0] == 16'h0000) ||
                ovf16 !== ((a16[15] ^ b16[15]) & (r16[15] ^ a16[15]))) begin
                errors++;
                $display("FAIL sweep_w16_d4: a=%h b=%h bin=%b got d=%h bor=%b z=%b ovf=%b lat=%0d need d=%h bor=%b lat=4",
                         a16, b16, bin, d16, bor16, zero16, ovf16, lat[4], r16[15:0], r16[16]);
            end
            release8();
        end
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bin = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        test_reset();
        test_arith("basic",     8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        test_arith("underflow", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        test_arith("borrow_in", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        test_arith("overflow",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        test_arith("zero",      8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
# serial_sub

Multi-cycle, parametrised N-bit subtractor: the sequential successor to the single-bit half subtractor. It computes `d = a - b - bin` over `WIDTH/DIGIT` clock cycles, LSB digit first. A ripple borrow is registered between digits. Operands enter through a valid/ready handshake, and results leave through one. It is the shared subtract engine for datapath blocks that trade latency for area.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width in bits; must be ≥ 2.
- `DIGIT`, 1: bits processed per cycle. Must divide `WIDTH`; `N = WIDTH/DIGIT` digits per operation.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operands `a`, `b`, `bin` are valid.
- `in_ready`, out, 1: block can accept operands; equals (state == IDLE).
- `a`, in, WIDTH: minuend.
- `b`, in, WIDTH: subtrahend.
- `bin`, in, 1: borrow in; subtracted at bit 0.
- `out_valid`, out, 1: result registers hold a completed result.
- `out_ready`, in, 1: consumer accepts the result.
- `d`, out, WIDTH: difference, modulo 2^WIDTH.
- `bor`, out, 1: borrow out of the MSB; 1 iff unsigned `a < b + bin`.
- `zero`, out, 1: `d == 0`.
- `ovf`, out, 1: two's-complement overflow, `(a[W-1]^b[W-1]) & (d[W-1]^a[W-1])`.

## Operation
States and transitions:
- IDLE: `in_ready=1`. On `in_valid & in_ready`: capture `a`, `b`; load the borrow register with `bin`; clear the digit counter and the `d` shift register; go to RUN.
- RUN: each cycle computes one DIGIT-bit slice as `{borrow', diff} = a_slice - b_slice - borrow`. The slice is taken from the low bits of the a/b shift registers. `diff` is written into the digit slot of `d` selected by the counter. Borrow is updated and the counter increments. On the cycle processing digit N-1, go to DONE.
- DONE: `out_valid=1`. `d`, `bor`, `zero`, `ovf` are stable and held. On `out_ready`, go to IDLE.

Other rules:
- `bor` is the final borrow register value. `zero` and `ovf` are registered on the RUN→DONE edge from the completed `d` and the captured operand MSBs.
- In RUN and DONE, `in_valid` is ignored and operands are not re-sampled; `in_ready=0`.
- No accept in the same cycle as the output handshake. The next operation starts no earlier than the cycle after returning to IDLE.
- The digit counter is `$clog2(N)` bits, minimum 1. Per-slice arithmetic is DIGIT+1 bits wide; no wider adder is inferred.
- Reset (any state, asynchronous) forces:
  - state = IDLE;
  - `out_valid=0`, `d=0`, `bor=0`, `zero=0`, `ovf=0`;
  - internal registers cleared;
  - `in_ready=1` while reset is asserted and after it.

## Timing
- Accept edge E0. Digit k is computed on edge E(k+1). `out_valid` rises on edge EN.
  - WIDTH=8, DIGIT=1: `out_valid` is high 8 cycles after accept.
  - WIDTH=8, DIGIT=4: 2 cycles. DIGIT=WIDTH: 1 cycle.
- `out_valid` deasserts on the edge where `out_valid & out_ready` is sampled high. `in_ready` is high from that edge.
- Minimum issue interval: N+2 cycles (accept, N RUN cycles ending in DONE, handshake, back to IDLE).
- `out_ready` held low: remain in DONE indefinitely with all outputs constant.
- `d`, `bor`, `zero`, `ovf` only change on the RUN→DONE edge or at reset. Intermediate digit writes are not visible as a valid result until `out_valid`.

## Test plan
- Basic: WIDTH=8, DIGIT=1; a=0x05, b=0x03, bin=0 → after 8 cycles `d=0x02`, `bor=0`, `zero=0`, `ovf=0`.
- Underflow and borrow-in: a=0x03, b=0x05, bin=0 → `d=0xFE`, `bor=1`. Then a=0x00, b=0x00, bin=1 → `d=0xFF`, `bor=1`, `zero=0`.
- Signed overflow and zero: a=0x80, b=0x01 → `d=0x7F`, `bor=0`, `ovf=1`. Then a=b=0x3C, bin=0 → `d=0x00`, `zero=1`, `bor=0`.
- Handshake and backpressure:
  - Hold `in_valid=1` with new operands throughout busy cycles; only the first set is consumed.
  - Hold `out_ready=0` for 5 cycles in DONE; outputs remain constant.
  - `in_ready` rises the edge after the output handshake.
- Reset mid-RUN: deassert `rst_n` asynchronously at digit 3 → immediately `out_valid=0`, `d=0`, `in_ready=1`. The next operation a=0xA5, b=0x5A yields `d=0x4B`, `bor=0` with no residue.
- Parameter sweep: DIGIT ∈ {1,2,4,8}, WIDTH=8, plus WIDTH=16, DIGIT=4.
  - Run 1000 random operands against the reference model `{bor,d} = a - b - bin`.
  - Latency must equal N exactly.
